apb_master_ctrl: RTL and testbench

APB initiator that drives the register-file slave of the encoder/decoder core (CTRL, DATA_IN, CODEWORD_WIDTH, NOISE at byte offsets 0x0/0x4/0x8/0xC). A host-side command port pushes read/write requests into a small command FIFO. An FSM issues them as APB SETUP/ACCESS transfers with no PREADY and returns one response per command. It sits between the test sequencer / host model and the register block.

---
 rtl/apb_master_pkg.sv | 26 ++
 rtl/apb_cmd_fifo.sv | 58 +++++
 rtl/apb_master_ctrl.sv | 159 +++++++++++++++
 tb/tb_apb_master_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator that talks to the encoder/decoder
// register file.
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        CAPTURE = 2'd3
    } apb_state_e;

    localparam int DEF_ADDR_WIDTH = 20;
    localparam int DEF_WORD       = 32;
    localparam int CMD_ENTRY_W    = 1 + DEF_ADDR_WIDTH + DEF_WORD;

    // Byte offsets of the slave's registers
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_CTRL           = 20'h0;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_DATA_IN        = 20'h4;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_CODEWORD_WIDTH = 20'h8;
    localparam logic [DEF_ADDR_WIDTH-1:0] REG_NOISE          = 20'hC;

    function automatic int cmd_entry_width(input int addrWidth, input int wordWidth);
        return 1 + addrWidth + wordWidth;
    endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command FIFO with show-ahead read data; full/empty come from pointers that
// carry one extra wrap bit.
module apb_cmd_fifo #(
    parameter int WIDTH = 53,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    logic             w_full;
    logic             w_empty;
    logic             w_doPush;
    logic             w_doPop;

    assign w_empty  = (r_wrPtr == r_rdPtr);
    assign w_full   = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                      (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);
    assign w_doPush = i_push & ~w_full;
    assign w_doPop  = i_pop & ~w_empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr[PTR_W-1:0]] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rdPtr[PTR_W-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/apb_master_ctrl.sv
// APB initiator: queues host read/write commands and issues them as SETUP/ACCESS
// transfers (no PREADY), returning one registered response per command in order.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int AMBA_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int AMBA_WORD       = DEF_WORD,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    output logic                       rsp_valid,
    output logic                       rsp_write,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       busy,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [AMBA_WORD-1:0]       PRDATA
);

    localparam int ENTRY_W = cmd_entry_width(AMBA_ADDR_WIDTH, AMBA_WORD);

    apb_state_e                 r_state;
    logic                       r_psel;
    logic                       r_penable;
    logic                       r_pwrite;
    logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
    logic [AMBA_WORD-1:0]       r_pwdata;
    logic                       r_rspValid;
    logic                       r_rspWrite;
    logic [AMBA_WORD-1:0]       r_rspRdata;

    logic [ENTRY_W-1:0]         w_pushEntry;
    logic [ENTRY_W-1:0]         w_headEntry;
    logic                       w_headWrite;
    logic [AMBA_ADDR_WIDTH-1:0] w_headAddr;
    logic [AMBA_WORD-1:0]       w_headWdata;
    logic                       w_fifoFull;
    logic                       w_fifoEmpty;
    logic                       w_pop;

    assign w_pushEntry = {cmd_write, cmd_addr, cmd_wdata};

    apb_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_wdata (w_pushEntry),
        .i_pop   (w_pop),
        .o_rdata (w_headEntry),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    assign w_headWrite = w_headEntry[ENTRY_W-1];
    assign w_headAddr  = w_headEntry[AMBA_WORD +: AMBA_ADDR_WIDTH];
    assign w_headWdata = w_headEntry[AMBA_WORD-1:0];

    // A new command is taken wherever the FSM could legally enter SETUP next.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            IDLE:    w_pop = ~w_fifoEmpty;
            ACCESS:  w_pop = r_pwrite & ~w_fifoEmpty;
            CAPTURE: w_pop = ~w_fifoEmpty;
            default: w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
            r_rspValid <= 1'b0;
            r_rspWrite <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_rspValid <= 1'b0;
            if (w_pop) begin
                r_pwrite <= w_headWrite;
                r_paddr  <= w_headAddr;
                r_pwdata <= w_headWdata;
            end
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    r_penable <= 1'b0;
                    if (r_pwrite) begin
                        r_rspValid <= 1'b1;
                        r_rspWrite <= 1'b1;
                        r_rspRdata <= '0;
                        if (w_pop) begin
                            r_state <= SETUP;
                        end else begin
                            r_state <= IDLE;
                            r_psel  <= 1'b0;
                        end
                    end else begin
                        r_state <= CAPTURE;
                        r_psel  <= 1'b0;
                    end
                end
                CAPTURE: begin
                    // The slave updated PRDATA at the end of ACCESS, so it is stable here.
                    r_rspValid <= 1'b1;
                    r_rspWrite <= 1'b0;
                    r_rspRdata <= PRDATA;
                    if (w_pop) begin
                        r_state <= SETUP;
                        r_psel  <= 1'b1;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ~w_fifoFull;
    assign busy      = (r_state != IDLE) | ~w_fifoEmpty;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PADDR     = r_paddr;
    assign PWDATA    = r_pwdata;
    assign rsp_valid = r_rspValid;
    assign rsp_write = r_rspWrite;
    assign rsp_rdata = r_rspRdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl with a four-register APB slave model that
// commits writes and updates PRDATA at the ACCESS-ending edge.
module tb_apb_master_ctrl;
    import apb_master_pkg::*;

    localparam int AW = 20;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdWrite;
    logic [AW-1:0] cmdAddr;
    logic [DW-1:0] cmdWdata;
    logic          rspValid;
    logic          rspWrite;
    logic [DW-1:0] rspRdata;
    logic          busy;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic [DW-1:0] slaveReg [4] = '{default: '0};

    int errors = 0;
    int checks = 0;
    int rspCount;
    logic [AW-1:0] wAddr [7];
    logic [DW-1:0] wData [7];

    always #5 clk = ~clk;

    apb_master_ctrl #(
        .AMBA_ADDR_WIDTH (AW),
        .AMBA_WORD       (DW),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmdValid),
        .cmd_ready (cmdReady),
        .cmd_write (cmdWrite),
        .cmd_addr  (cmdAddr),
        .cmd_wdata (cmdWdata),
        .rsp_valid (rspValid),
        .rsp_write (rspWrite),
        .rsp_rdata (rspRdata),
        .busy      (busy),
        .PSEL      (psel),
        .PENABLE   (penable),
        .PWRITE    (pwrite),
        .PADDR     (paddr),
        .PWDATA    (pwdata),
        .PRDATA    (prdata)
    );

    always @(posedge clk) begin
        if (psel && penable) begin
            if (pwrite) slaveReg[paddr[3:2]] <= pwdata;
            else        prdata <= slaveReg[paddr[3:2]];
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a,
                                 input logic [DW-1:0] d);
        cmdValid = v;
        cmdWrite = w;
        cmdAddr  = a;
        cmdWdata = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        wAddr[0] = REG_CTRL;           wData[0] = 32'hA0;
        wAddr[1] = REG_DATA_IN;        wData[1] = 32'hA1;
        wAddr[2] = REG_CODEWORD_WIDTH; wData[2] = 32'hA2;
        wAddr[3] = REG_CTRL;           wData[3] = 32'h11;
        wAddr[4] = REG_DATA_IN;        wData[4] = 32'h22;
        wAddr[5] = REG_CODEWORD_WIDTH; wData[5] = 32'h33;
        wAddr[6] = REG_NOISE;          wData[6] = 32'h44;

        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        #12;
        checkBit("rst_psel", psel, 1'b0);
        checkBit("rst_penable", penable, 1'b0);
        checkBit("rst_pwrite", pwrite, 1'b0);
        checkOutput("rst_paddr", 32'(paddr), 32'h0);
        checkOutput("rst_pwdata", pwdata, 32'h0);
        checkBit("rst_rsp_valid", rspValid, 1'b0);
        checkBit("rst_rsp_write", rspWrite, 1'b0);
        checkOutput("rst_rsp_rdata", rspRdata, 32'h0);
        checkBit("rst_busy", busy, 1'b0);
        checkBit("rst_cmd_ready", cmdReady, 1'b1);
        @(posedge clk);
        #3 rst = 1'b1;
        tick();
        tick();

        $display("[TB] single write then read of CTRL");
        applyStimulus(1'b1, 1'b1, REG_CTRL, 32'hA5);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkBit("w1_idle_psel", psel, 1'b0);
        checkBit("w1_idle_busy", busy, 1'b1);
        tick();
        checkBit("w1_setup_psel", psel, 1'b1);
        checkBit("w1_setup_penable", penable, 1'b0);
        checkBit("w1_setup_pwrite", pwrite, 1'b1);
        checkOutput("w1_setup_paddr", 32'(paddr), 32'h0);
        checkOutput("w1_setup_pwdata", pwdata, 32'hA5);
        tick();
        checkBit("w1_access_psel", psel, 1'b1);
        checkBit("w1_access_penable", penable, 1'b1);
        checkBit("w1_access_rsp_valid", rspValid, 1'b0);
        tick();
        checkBit("w1_rsp_valid", rspValid, 1'b1);
        checkBit("w1_rsp_write", rspWrite, 1'b1);
        checkOutput("w1_rsp_rdata", rspRdata, 32'h0);
        checkBit("w1_after_psel", psel, 1'b0);
        checkBit("w1_after_penable", penable, 1'b0);
        tick();
        checkBit("w1_rsp_pulse_end", rspValid, 1'b0);
        checkBit("w1_busy_end", busy, 1'b0);
        checkOutput("w1_slave_ctrl", slaveReg[0], 32'hA5);

        applyStimulus(1'b1, 1'b0, REG_CTRL, 32'h1234);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkBit("r1_idle_psel", psel, 1'b0);
        checkBit("r1_idle_busy", busy, 1'b1);
        tick();
        checkBit("r1_setup_psel", psel, 1'b1);
        checkBit("r1_setup_penable", penable, 1'b0);
        checkBit("r1_setup_pwrite", pwrite, 1'b0);
        checkOutput("r1_setup_pwdata", pwdata, 32'h1234);
        tick();
        checkBit("r1_access_psel", psel, 1'b1);
        checkBit("r1_access_penable", penable, 1'b1);
        tick();
        checkBit("r1_capture_psel", psel, 1'b0);
        checkBit("r1_capture_penable", penable, 1'b0);
        checkBit("r1_capture_rsp_valid", rspValid, 1'b0);
        tick();
        checkBit("r1_rsp_valid", rspValid, 1'b1);
        checkBit("r1_rsp_write", rspWrite, 1'b0);
        checkOutput("r1_rsp_rdata", rspRdata, 32'hA5);
        tick();
        checkBit("r1_rsp_pulse_end", rspValid, 1'b0);
        checkBit("r1_busy_end", busy, 1'b0);

        // Seven writes on consecutive cycles fill the FIFO at cycle 7; an eighth
        // push held during that full cycle (which also pops) must be dropped.
        $display("[TB] write burst with full FIFO");
        rspCount = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 7)       applyStimulus(1'b1, 1'b1, wAddr[c], wData[c]);
            else if (c == 7) applyStimulus(1'b1, 1'b1, REG_NOISE, 32'hBAD);
            else             applyStimulus(1'b0, 1'b0, '0, '0);
            checkBit($sformatf("wb_rsp_valid_c%0d", c), rspValid,
                     (c >= 4) && (c <= 16) && (c % 2 == 0));
            if ((c >= 4) && (c <= 16) && (c % 2 == 0)) begin
                rspCount++;
                checkBit($sformatf("wb_rsp_write_c%0d", c), rspWrite, 1'b1);
                checkOutput($sformatf("wb_rsp_rdata_c%0d", c), rspRdata, 32'h0);
            end
            if ((c >= 2) && (c <= 15)) begin
                checkBit($sformatf("wb_psel_c%0d", c), psel, 1'b1);
                checkBit($sformatf("wb_penable_c%0d", c), penable, c % 2 == 1);
                if (c % 2 == 0)
                    checkOutput($sformatf("wb_pwdata_c%0d", c), pwdata, wData[(c - 2) / 2]);
            end
            if (c == 6) checkBit("wb_ready_c6", cmdReady, 1'b1);
            if (c == 7) checkBit("wb_ready_full_c7", cmdReady, 1'b0);
            if (c == 8) checkBit("wb_ready_back_c8", cmdReady, 1'b1);
            tick();
        end
        checkOutput("wb_rsp_count", 32'(rspCount), 32'd7);
        checkBit("wb_busy_end", busy, 1'b0);
        checkOutput("wb_slave_noise", slaveReg[3], 32'h44);

        $display("[TB] read burst of all four registers");
        for (int c = 0; c < 17; c++) begin
            if (c < 4) applyStimulus(1'b1, 1'b0, AW'(c * 4), 32'h0);
            else       applyStimulus(1'b0, 1'b0, '0, '0);
            checkBit($sformatf("rb_rsp_valid_c%0d", c), rspValid,
                     (c >= 5) && (c <= 14) && ((c - 5) % 3 == 0));
            if ((c >= 5) && (c <= 14) && ((c - 5) % 3 == 0)) begin
                checkBit($sformatf("rb_rsp_write_c%0d", c), rspWrite, 1'b0);
                checkOutput($sformatf("rb_rsp_rdata_c%0d", c), rspRdata,
                            32'h11 * (32'((c - 5) / 3) + 32'd1));
            end
            if ((c >= 2) && (c <= 13)) begin
                checkBit($sformatf("rb_psel_c%0d", c), psel, (c - 2) % 3 != 2);
                checkBit($sformatf("rb_penable_c%0d", c), penable, (c - 2) % 3 == 1);
                if ((c - 2) % 3 == 0)
                    checkOutput($sformatf("rb_paddr_c%0d", c), 32'(paddr), 32'(((c - 2) / 3) * 4));
            end
            tick();
        end
        checkBit("rb_busy_end", busy, 1'b0);

        $display("[TB] write then read of CODEWORD_WIDTH with no gap");
        applyStimulus(1'b1, 1'b1, REG_CODEWORD_WIDTH, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 1'b0, REG_CODEWORD_WIDTH, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        checkBit("iw_setup_psel", psel, 1'b1);
        checkBit("iw_setup_pwrite", pwrite, 1'b1);
        tick();
        checkBit("iw_access_penable", penable, 1'b1);
        checkBit("iw_access_pwrite", pwrite, 1'b1);
        tick();
        checkBit("ir_setup_psel", psel, 1'b1);
        checkBit("ir_setup_penable", penable, 1'b0);
        checkBit("ir_setup_pwrite", pwrite, 1'b0);
        checkOutput("ir_setup_paddr", 32'(paddr), 32'h8);
        checkBit("iw_rsp_valid", rspValid, 1'b1);
        checkBit("iw_rsp_write", rspWrite, 1'b1);
        tick();
        checkBit("ir_access_psel", psel, 1'b1);
        checkBit("ir_access_penable", penable, 1'b1);
        tick();
        checkBit("ir_capture_psel", psel, 1'b0);
        checkBit("ir_capture_rsp_valid", rspValid, 1'b0);
        tick();
        checkBit("ir_rsp_valid", rspValid, 1'b1);
        checkBit("ir_rsp_write", rspWrite, 1'b0);
        checkOutput("ir_rsp_rdata", rspRdata, 32'hDEAD_BEEF);
        tick();

        $display("[TB] reset during ACCESS of a DATA_IN write");
        applyStimulus(1'b1, 1'b1, REG_DATA_IN, 32'hCAFE_0001);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        checkBit("rs_access_psel", psel, 1'b1);
        checkBit("rs_access_penable", penable, 1'b1);
        checkOutput("rs_access_paddr", 32'(paddr), 32'h4);
        #2 rst = 1'b0;
        #1;
        checkBit("rs_psel", psel, 1'b0);
        checkBit("rs_penable", penable, 1'b0);
        checkBit("rs_pwrite", pwrite, 1'b0);
        checkOutput("rs_paddr", 32'(paddr), 32'h0);
        checkOutput("rs_pwdata", pwdata, 32'h0);
        checkBit("rs_rsp_valid", rspValid, 1'b0);
        checkBit("rs_busy", busy, 1'b0);
        checkBit("rs_cmd_ready", cmdReady, 1'b1);
        tick();
        checkOutput("rs_slave_data_in", slaveReg[1], 32'h22);
        checkBit("rs_hold_rsp_valid", rspValid, 1'b0);
        #2 rst = 1'b1;
        tick();
        checkBit("rs_after_rsp_valid", rspValid, 1'b0);
        checkBit("rs_after_busy", busy, 1'b0);
        checkBit("rs_after_psel", psel, 1'b0);
        tick();
        checkOutput("rs_after_slave_data_in", slaveReg[1], 32'h22);

        applyStimulus(1'b1, 1'b0, REG_DATA_IN, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        tick();
        checkBit("rs_read_rsp_valid", rspValid, 1'b1);
        checkOutput("rs_read_rsp_rdata", rspRdata, 32'h22);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
